// File: rtl/r5p_lsu_if.sv
// rtl/r5p_lsu_if.sv - single-outstanding data bus between the LSU and memory
interface r5p_lsu_if #(
   parameter int XLEN = 32,
   parameter int BW   = XLEN/8
);
   logic            ls_vld;
   logic            ls_wen;
   logic [XLEN-1:0] ls_adr;
   logic [BW-1:0]   ls_ben;
   logic [XLEN-1:0] ls_wdt;
   logic            ls_rdy;
   logic [XLEN-1:0] ls_rdt;

   modport master (
      output ls_vld, ls_wen, ls_adr, ls_ben, ls_wdt,
      input  ls_rdy, ls_rdt
   );

   modport slave (
      input  ls_vld, ls_wen, ls_adr, ls_ben, ls_wdt,
      output ls_rdy, ls_rdt
   );
endinterface

// File: rtl/r5p_lsu.sv
// rtl/r5p_lsu.sv - load/store unit: aligned bus requests, lane steering, load extension
// Misaligned accesses are flagged in IDLE and never reach the bus.
module r5p_lsu #(
   parameter int XLEN = 32,
   parameter int BW   = XLEN/8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ld,
   input  logic            st,
   input  logic [2:0]      f3,
   input  logic [XLEN-1:0] adr,
   input  logic [XLEN-1:0] wdt,
   output logic [XLEN-1:0] rdt,
   output logic            rdv,
   output logic            stall,
   output logic            mis,
   r5p_lsu_if.master       bus
);
   localparam int OW = $clog2(BW);

   typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

   state_t          state;
   logic [OW-1:0]   off_r;
   logic [2:0]      f3_r;
   logic            req;
   logic            misal;
   logic [BW-1:0]   msk;
   logic [XLEN-1:0] rep;
   logic [XLEN-1:0] sh;

   always_comb begin
      misal = 1'b0;
      msk   = BW'(1);
      rep   = {BW{wdt[7:0]}};
      case (f3[1:0])
         2'b01: begin
            misal = adr[0];
            msk   = BW'(3);
            rep   = {(BW/2){wdt[15:0]}};
         end
         2'b10: begin
            misal = |adr[1:0];
            msk   = BW'(15);
            rep   = {(BW/4){wdt[31:0]}};
         end
         2'b11: begin
            misal = |adr[2:0];
            msk   = '1;
            rep   = wdt;
         end
         default: ;
      endcase
   end

   assign req = (ld | st) && (state == IDLE);
   assign mis = req & misal;
   assign rdv = (state == RSP);

   // A store completes in the REQ cycle that sees ls_rdy; a load needs the RSP cycle.
   always_comb begin
      stall = 1'b0;
      case (state)
         IDLE:    stall = req & ~misal;
         REQ:     stall = ~(bus.ls_rdy & bus.ls_wen);
         default: stall = 1'b0;
      endcase
   end

   always_comb begin
      rdt = '0;
      sh  = bus.ls_rdt >> {off_r, 3'b000};
      if (state == RSP) begin
         case (f3_r)
            3'b000:  rdt = XLEN'($signed(sh[7:0]));
            3'b001:  rdt = XLEN'($signed(sh[15:0]));
            3'b010:  rdt = XLEN'($signed(sh[31:0]));
            3'b011:  rdt = (XLEN == 64) ? sh : '0;
            3'b100:  rdt = XLEN'(sh[7:0]);
            3'b101:  rdt = XLEN'(sh[15:0]);
            3'b110:  rdt = XLEN'(sh[31:0]);
            default: rdt = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         bus.ls_vld <= 1'b0;
         bus.ls_wen <= 1'b0;
         bus.ls_adr <= '0;
         bus.ls_ben <= '0;
         bus.ls_wdt <= '0;
         off_r      <= '0;
         f3_r       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req & ~misal) begin
                  bus.ls_adr <= adr & ~XLEN'(BW-1);
                  bus.ls_wen <= st;
                  bus.ls_ben <= msk << adr[OW-1:0];
                  bus.ls_wdt <= rep << {adr[OW-1:0], 3'b000};
                  off_r      <= adr[OW-1:0];
                  f3_r       <= f3;
                  bus.ls_vld <= 1'b1;
                  state      <= REQ;
               end
            end
            REQ: begin
               if (bus.ls_rdy) begin
                  bus.ls_vld <= 1'b0;
                  state      <= bus.ls_wen ? IDLE : RSP;
               end
            end
            RSP:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
